sseg_display_ctrl: RTL

SSEG_DISPLAY_CTRL -- requirements
Module: sseg_display_ctrl

---
 rtl/sseg_display_ctrl_if.sv | 23 ++
 rtl/sseg_display_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/sseg_display_ctrl_if.sv
// Bundle of the request and display signals of the seven-segment display controller.
// The master side issues load requests; the slave side is the controller itself.
interface sseg_display_ctrl_if;
   logic        load;
   logic [15:0] value;
   logic        hex_mode;
   logic        signed_mode;
   logic        busy;
   logic        done;
   logic [23:0] digits;
   logic [5:0]  neg;
   logic [5:0]  en;

   modport master (
      output load, value, hex_mode, signed_mode,
      input  busy, done, digits, neg, en
   );

   modport slave (
      input  load, value, hex_mode, signed_mode,
      output busy, done, digits, neg, en
   );
endinterface

// File: rtl/sseg_display_ctrl.sv
// Six-digit seven-segment display formatter.
// A load captures a 16-bit value and its mode bits, takes the magnitude, converts it
// to five BCD digits by double-dabble, then formats digits, sign and enables.
// Every request takes exactly 18 edges from acceptance to the done pulse.
module sseg_display_ctrl (
   input  logic              clk,
   input  logic              reset,
   sseg_display_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ABS, CONV, FMT} state_t;

   state_t      state_q;
   logic [15:0] value_q;
   logic        hex_q;
   logic        signed_q;
   logic        neg_flag_q;
   // Upper 20 bits: BCD accumulator (5 digits); lower 16 bits: binary still to shift in.
   logic [35:0] conv_q;
   logic [4:0]  cnt_q;
   logic        busy_q;
   logic        done_q;
   logic [23:0] digits_q;
   logic [5:0]  neg_q;
   logic [5:0]  en_q;

   logic [16:0] mag_d;
   logic        neg_flag_d;
   logic [19:0] bcd_adj_d;
   logic [2:0]  k_d;
   logic [5:0]  en_dec_d;
   logic [5:0]  neg_dec_d;

   // Magnitude of the captured value; 17 bits so that -32768 becomes +32768.
   always_comb begin
      neg_flag_d = signed_q & ~hex_q & value_q[15];
      mag_d      = neg_flag_d ? (17'd0 - {value_q[15], value_q}) : {1'b0, value_q};
   end

   // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      bcd_adj_d = '0;
      for (int i = 0; i < 5; i++) begin
         if (conv_q[16 + 4*i +: 4] >= 4'd5)
            bcd_adj_d[4*i +: 4] = conv_q[16 + 4*i +: 4] + 4'd3;
         else
            bcd_adj_d[4*i +: 4] = conv_q[16 + 4*i +: 4];
      end
   end

   // Decimal formatting: find the leading nonzero digit, enable up to it, place the sign above it.
   always_comb begin
      k_d       = '0;
      en_dec_d  = '0;
      neg_dec_d = '0;
      for (int i = 1; i < 5; i++) begin
         if (conv_q[16 + 4*i +: 4] != 4'd0)
            k_d = 3'(i);
      end
      for (int i = 0; i < 6; i++) begin
         if (i <= int'(k_d))
            en_dec_d[i] = 1'b1;
      end
      if (neg_flag_q) begin
         en_dec_d[k_d + 3'd1]  = 1'b1;
         neg_dec_d[k_d + 3'd1] = 1'b1;
      end
   end

   // Control FSM with registered display outputs; reset blanks the display and drops any conversion.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (reset) begin
         state_q    <= IDLE;
         value_q    <= '0;
         hex_q      <= 1'b0;
         signed_q   <= 1'b0;
         neg_flag_q <= 1'b0;
         conv_q     <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         digits_q   <= '0;
         neg_q      <= '0;
         en_q       <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.load) begin
                  value_q  <= bus.value;
                  hex_q    <= bus.hex_mode;
                  signed_q <= bus.signed_mode;
                  busy_q   <= 1'b1;
                  state_q  <= ABS;
               end
            end
            ABS: begin
               // Bit 16 of the magnitude seeds the BCD accumulator so the whole 17-bit value converts.
               conv_q     <= {19'd0, mag_d};
               neg_flag_q <= neg_flag_d;
               cnt_q      <= '0;
               state_q    <= CONV;
            end
            CONV: begin
               // Rotate rather than shift: the wrapped bit is always 0 for 5-digit results.
               conv_q <= {bcd_adj_d[18:0], conv_q[15:0], bcd_adj_d[19]};
               cnt_q  <= cnt_q + 5'd1;
               if (cnt_q == 5'd15)
                  state_q <= FMT;
            end
            FMT: begin
               if (hex_q) begin
                  digits_q <= {8'd0, value_q};
                  en_q     <= 6'b001111;
                  neg_q    <= 6'b000000;
               end else begin
                  digits_q <= {4'd0, conv_q[35:16]};
                  en_q     <= en_dec_d;
                  neg_q    <= neg_dec_d;
               end
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.digits = digits_q;
   assign bus.neg    = neg_q;
   assign bus.en     = en_q;

endmodule
